sprite_draw_scheduler: RTL and testbench
========================================

// Module: sprite_draw_scheduler
// PURPOSE
//  Shares the single VGA pixel-write port among N sprite drawers (6 birds, hunter, laser).
//  On each frame tick, visits active sprites in index order: erase at last-drawn position, then draw at new position.
//  Snapshots each sprite's base position at frame start. Muxes the selected drawer's pixel stream onto x/y/colour/plot.
//  Sits between the per-sprite position counters/drawers and vga_adapter.
// PARAMETERS
//  N_SPRITES     8       number of requesters (index 0 visited first)
//  ERASE_COLOUR  3'b000  colour driven during erase phases
//  TIMEOUT       255     max cycles per phase waiting for draw_done before abort (8-bit counter)
// PORTS
//  CLOCK_50      in   1          system clock
//  reset         in   1          synchronous, active-high
//  frame_tick    in   1          1-cycle pulse per frame; starts a pass
//  active        in   N          sprite i participates this frame (sampled at tick)
//  base_x_in     in   8*N        sprite i base x (sampled at tick)
//  base_y_in     in   7*N        sprite i base y (sampled at tick)
//  sprite_colour in   3*N        sprite i draw colour
//  draw_done     in   N          drawer i finished its pixel sequence (level)
//  pix_x_in      in   8*N        drawer i current pixel x
//  pix_y_in      in   7*N        drawer i current pixel y
//  start         out  N          1-cycle restart pulse to drawer i
//  base_x        out  8          shared base x for the selected drawer
//  base_y        out  7          shared base y for the selected drawer
//  x / y         out  8 / 7      pixel address to vga_adapter
//  colour        out  3          pixel colour to vga_adapter
//  plot          out  1          pixel write enable
//  busy          out  1          pass in progress
//  frame_overrun out  1          sticky: tick arrived while busy
//  timeout_err   out  1          sticky: a phase hit TIMEOUT
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, index 0, prev_valid[] = 0, sticky flags cleared. Same on reset mid-pass.
//  States: IDLE, SCAN, START_ERASE, ERASE, START_DRAW, DRAW, NEXT.
//  IDLE: on frame_tick -> capture active/base_x_in/base_y_in into snap regs, index=0, -> SCAN (busy=1 next cycle).
//  SCAN: if index==N -> IDLE. Else if !snap_active[index] -> index+1, stay SCAN (1 cycle per skipped sprite).
//   Else -> START_ERASE if prev_valid[index], otherwise START_DRAW.
//  START_ERASE: start[index]=1 one cycle; base = prev pos; plot=0 -> ERASE.
//  ERASE: base = prev pos; plot = !draw_done[index]; colour=ERASE_COLOUR; x/y = pix from drawer index.
//   draw_done[index]=1 -> START_DRAW (plot=0 that cycle).
//  START_DRAW: start pulse; base = snap pos -> DRAW.
//  DRAW: as ERASE but colour = sprite_colour[index], base = snap pos. On done: prev pos <= snap pos,
//   prev_valid[index] <= 1 -> NEXT.
//  NEXT: index+1 -> SCAN.
//  start is one-hot or zero; never asserted outside START_* states.
//  Phase counter cleared in START_*; reaching TIMEOUT in ERASE/DRAW -> timeout_err=1, skip to NEXT
//   (prev not updated).
//  frame_tick outside IDLE: ignored, frame_overrun=1. Tick in the cycle the pass returns to IDLE is also dropped.
//  x/y/colour are 0 whenever plot=0. Coordinate widths pass through; no arithmetic on pixel addresses.
//  Latency: tick -> first start pulse = 2 cycles (SCAN + START) for active sprite 0.
// CONFIGURATION
//  SCHED_INACTIVE_ERASE_EN defined: a sprite with prev_valid=1 but snap_active=0 receives START_ERASE/ERASE only
//   at its prev pos, then prev_valid cleared (no draw).
//  Undefined: inactive sprites skipped entirely; their last image stays on screen; prev_valid unchanged.
// TESTING
//  N=2, drawer models emit 13 pixels then done. Tick, active=01, base0=(5,7) -> one start[0], 13 plots colour=sprite_colour[0], no erase.
//  Second tick, base0=(6,7) -> 13 plots colour 000 around base (5,7), then 13 plots at (6,7); busy drops after NEXT/SCAN.
//  active=11 -> sprite 0 fully finished before start[1]; start never has 2 bits set; plot never high in START_* cycles.
//  Tick during pass -> frame_overrun=1, no second pass; reset mid-DRAW -> next cycle all outputs 0, next tick draws with no erase.
//  Drawer 1 never asserts done -> timeout_err=1 after 255 cycles, pass completes, busy=0.
//  SCHED_INACTIVE_ERASE_EN: sprite 0 drawn, then active=00 tick -> exactly 13 erase plots, no draw; undefined -> 0 plots.

Source files
------------

// File: rtl/sprite_draw_scheduler.sv
// Time-shares the VGA pixel-write port among N sprite drawers: per frame, erase each active sprite at its last
// drawn position, then redraw it at the position snapshotted on the tick. Optional macro: SCHED_INACTIVE_ERASE_EN.
module sprite_draw_scheduler #(
  parameter int          N_SPRITES    = 8,
  parameter logic [2:0]  ERASE_COLOUR = 3'b000,
  parameter int          TIMEOUT      = 255
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     frame_tick,
  input  logic [N_SPRITES-1:0]     active,
  input  logic [8*N_SPRITES-1:0]   base_x_in,
  input  logic [7*N_SPRITES-1:0]   base_y_in,
  input  logic [3*N_SPRITES-1:0]   sprite_colour,
  input  logic [N_SPRITES-1:0]     draw_done,
  input  logic [8*N_SPRITES-1:0]   pix_x_in,
  input  logic [7*N_SPRITES-1:0]   pix_y_in,
  output logic [N_SPRITES-1:0]     start,
  output logic [7:0]               base_x,
  output logic [6:0]               base_y,
  output logic [7:0]               x,
  output logic [6:0]               y,
  output logic [2:0]               colour,
  output logic                     plot,
  output logic                     busy,
  output logic                     frame_overrun,
  output logic                     timeout_err,
  output logic [2:0]               dbg_state_o
);

  localparam int         IW = $clog2(N_SPRITES + 1);
  localparam logic [7:0] TO = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_SCAN        = 3'd1,
    S_START_ERASE = 3'd2,
    S_ERASE       = 3'd3,
    S_START_DRAW  = 3'd4,
    S_DRAW        = 3'd5,
    S_NEXT        = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [7:0]      cnt_q, cnt_d;

  logic [N_SPRITES-1:0] snap_active_q;
  logic [7:0]           snap_x_q [N_SPRITES];
  logic [6:0]           snap_y_q [N_SPRITES];
  logic [N_SPRITES-1:0] prev_valid_q;
  logic [7:0]           prev_x_q [N_SPRITES];
  logic [6:0]           prev_y_q [N_SPRITES];
  logic                 overrun_q;
  logic                 timeout_q;

  logic                 capture;
  logic                 set_prev;
  logic                 clr_prev;
  logic                 ovr_set;
  logic                 to_set;

  // Per-index view of the currently selected sprite; all zero when idx_q == N_SPRITES.
  logic       cur_active, cur_prev_valid, cur_done;
  logic [7:0] cur_snap_x, cur_prev_x, cur_pix_x;
  logic [6:0] cur_snap_y, cur_prev_y, cur_pix_y;
  logic [2:0] cur_colour;

  always_comb begin
    cur_active     = 1'b0;
    cur_prev_valid = 1'b0;
    cur_done       = 1'b0;
    cur_snap_x     = '0;
    cur_snap_y     = '0;
    cur_prev_x     = '0;
    cur_prev_y     = '0;
    cur_pix_x      = '0;
    cur_pix_y      = '0;
    cur_colour     = '0;
    for (int i = 0; i < N_SPRITES; i++) begin
      if (idx_q == IW'(i)) begin
        cur_active     = snap_active_q[i];
        cur_prev_valid = prev_valid_q[i];
        cur_done       = draw_done[i];
        cur_snap_x     = snap_x_q[i];
        cur_snap_y     = snap_y_q[i];
        cur_prev_x     = prev_x_q[i];
        cur_prev_y     = prev_y_q[i];
        cur_pix_x      = pix_x_in[8*i +: 8];
        cur_pix_y      = pix_y_in[7*i +: 7];
        cur_colour     = sprite_colour[3*i +: 3];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    start    = '0;
    base_x   = '0;
    base_y   = '0;
    x        = '0;
    y        = '0;
    colour   = '0;
    plot     = 1'b0;
    capture  = 1'b0;
    set_prev = 1'b0;
    clr_prev = 1'b0;
    to_set   = 1'b0;
    ovr_set  = frame_tick && (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (frame_tick) begin
          capture = 1'b1;
          idx_d   = '0;
          state_d = S_SCAN;
        end
      end

      S_SCAN: begin
        if (idx_q == IW'(N_SPRITES)) begin
          state_d = S_IDLE;
        end else if (!cur_active) begin
`ifdef SCHED_INACTIVE_ERASE_EN
          if (cur_prev_valid) state_d = S_START_ERASE;
          else                idx_d   = idx_q + 1'b1;
`else
          idx_d = idx_q + 1'b1;
`endif
        end else if (cur_prev_valid) begin
          state_d = S_START_ERASE;
        end else begin
          state_d = S_START_DRAW;
        end
      end

      S_START_ERASE: begin
        for (int i = 0; i < N_SPRITES; i++) start[i] = (idx_q == IW'(i));
        base_x  = cur_prev_x;
        base_y  = cur_prev_y;
        cnt_d   = '0;
        state_d = S_ERASE;
      end

      S_ERASE: begin
        base_x = cur_prev_x;
        base_y = cur_prev_y;
        if (cur_done) begin
`ifdef SCHED_INACTIVE_ERASE_EN
          if (!cur_active) begin
            clr_prev = 1'b1;
            state_d  = S_NEXT;
          end else begin
            state_d  = S_START_DRAW;
          end
`else
          state_d = S_START_DRAW;
`endif
        end else begin
          plot   = 1'b1;
          x      = cur_pix_x;
          y      = cur_pix_y;
          colour = ERASE_COLOUR;
          if (cnt_q == TO) begin
            to_set  = 1'b1;
            state_d = S_NEXT;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      S_START_DRAW: begin
        for (int i = 0; i < N_SPRITES; i++) start[i] = (idx_q == IW'(i));
        base_x  = cur_snap_x;
        base_y  = cur_snap_y;
        cnt_d   = '0;
        state_d = S_DRAW;
      end

      S_DRAW: begin
        base_x = cur_snap_x;
        base_y = cur_snap_y;
        if (cur_done) begin
          set_prev = 1'b1;
          state_d  = S_NEXT;
        end else begin
          plot   = 1'b1;
          x      = cur_pix_x;
          y      = cur_pix_y;
          colour = cur_colour;
          if (cnt_q == TO) begin
            to_set  = 1'b1;
            state_d = S_NEXT;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      S_NEXT: begin
        idx_d   = idx_q + 1'b1;
        state_d = S_SCAN;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      snap_active_q <= '0;
      prev_valid_q  <= '0;
      overrun_q     <= 1'b0;
      timeout_q     <= 1'b0;
      for (int i = 0; i < N_SPRITES; i++) begin
        snap_x_q[i] <= '0;
        snap_y_q[i] <= '0;
        prev_x_q[i] <= '0;
        prev_y_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        snap_active_q <= active;
        for (int i = 0; i < N_SPRITES; i++) begin
          snap_x_q[i] <= base_x_in[8*i +: 8];
          snap_y_q[i] <= base_y_in[7*i +: 7];
        end
      end
      // A completed draw becomes the position to erase next frame.
      for (int i = 0; i < N_SPRITES; i++) begin
        if (idx_q == IW'(i)) begin
          if (set_prev) begin
            prev_x_q[i]     <= snap_x_q[i];
            prev_y_q[i]     <= snap_y_q[i];
            prev_valid_q[i] <= 1'b1;
          end
          if (clr_prev) prev_valid_q[i] <= 1'b0;
        end
      end
      if (ovr_set) overrun_q <= 1'b1;
      if (to_set)  timeout_q <= 1'b1;
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign frame_overrun = overrun_q;
  assign timeout_err   = timeout_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Bench for sprite_draw_scheduler with two 13-pixel drawer models and a pixel scoreboard.
// Honors SCHED_INACTIVE_ERASE_EN for the inactive-sprite scenario.
module tb_sprite_draw_scheduler;
  localparam int N  = 2;
  localparam int PW = 18;

  logic             CLOCK_50 = 1'b0;
  logic             reset;
  logic             frame_tick;
  logic [N-1:0]     active;
  logic [8*N-1:0]   base_x_in;
  logic [7*N-1:0]   base_y_in;
  logic [3*N-1:0]   sprite_colour;
  logic [N-1:0]     draw_done;
  logic [8*N-1:0]   pix_x_in;
  logic [7*N-1:0]   pix_y_in;
  logic [N-1:0]     start;
  logic [7:0]       base_x, x;
  logic [6:0]       base_y, y;
  logic [2:0]       colour;
  logic             plot, busy, frame_overrun, timeout_err;
  logic [2:0]       dbg_state;

  sprite_draw_scheduler #(.N_SPRITES(N), .ERASE_COLOUR(3'b000), .TIMEOUT(255)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .frame_tick(frame_tick), .active(active),
    .base_x_in(base_x_in), .base_y_in(base_y_in), .sprite_colour(sprite_colour),
    .draw_done(draw_done), .pix_x_in(pix_x_in), .pix_y_in(pix_y_in), .start(start),
    .base_x(base_x), .base_y(base_y), .x(x), .y(y), .colour(colour), .plot(plot),
    .busy(busy), .frame_overrun(frame_overrun), .timeout_err(timeout_err),
    .dbg_state_o(dbg_state)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_errors = 0;
  logic [PW-1:0] exp_q[$];
  int  n_starts = 0;
  int  last_idx = 0;
  int  exp_at_start1 = -1;
  bit  ignore1 = 1'b0;
  bit  hang1 = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drawer models: 13 pixels in a 4-wide raster from the base latched at start.
  logic [7:0] dcnt [N];
  logic [7:0] dbx  [N];
  logic [6:0] dby  [N];
  always @(posedge CLOCK_50) begin
    for (int i = 0; i < N; i++) begin
      if (reset) begin
        draw_done[i] <= 1'b1;
        dcnt[i]      <= '0;
        dbx[i]       <= '0;
        dby[i]       <= '0;
      end else if (start[i]) begin
        draw_done[i] <= 1'b0;
        dcnt[i]      <= '0;
        dbx[i]       <= base_x;
        dby[i]       <= base_y;
      end else if (!draw_done[i]) begin
        if (dcnt[i] == 8'd12 && !(i == 1 && hang1)) draw_done[i] <= 1'b1;
        else dcnt[i] <= dcnt[i] + 8'd1;
      end
    end
  end
  always_comb begin
    for (int i = 0; i < N; i++) begin
      pix_x_in[8*i +: 8] = dbx[i] + {6'd0, dcnt[i][1:0]};
      pix_y_in[7*i +: 7] = dby[i] + 7'(dcnt[i] >> 2);
    end
  end

  task automatic push_sprite(input int bx, input int by, input logic [2:0] col);
    for (int k = 0; k < 13; k++) exp_q.push_back({8'(bx + k % 4), 7'(by + k / 4), col});
  endtask

  // Scoreboard / protocol monitor, sampled mid-cycle.
  always @(negedge CLOCK_50) begin
    if (!reset) begin
      if (start != '0) begin
        n_starts++;
        check("start_onehot", 32'($countones(start)), 32'd1);
        check("plot_in_start", {31'd0, plot}, 32'd0);
        last_idx = start[1] ? 1 : 0;
        if (start[1] && exp_at_start1 >= 0)
          check("sprite0_done_before_start1", 32'(exp_q.size()), 32'(exp_at_start1));
      end
      if (plot) begin
        if (!(ignore1 && last_idx == 1)) begin
          if (exp_q.size() == 0) check("unexpected_plot", {14'd0, x, y, colour}, 32'd0);
          else check("pixel", {14'd0, x, y, colour}, {14'd0, exp_q.pop_front()});
        end
      end else begin
        check("xyc_zero_no_plot", {14'd0, x, y, colour}, 32'd0);
      end
    end
  end

  task automatic set_pos(input int bx0, input int by0, input int bx1, input int by1);
    base_x_in = {8'(bx1), 8'(bx0)};
    base_y_in = {7'(by1), 7'(by0)};
  endtask

  task automatic tick_pass(input logic [N-1:0] act, input logic [N-1:0] first_start);
    @(negedge CLOCK_50);
    active     = act;
    frame_tick = 1'b1;
    n_starts   = 0;
    @(negedge CLOCK_50);
    frame_tick = 1'b0;
    check("busy_after_tick", {31'd0, busy}, 32'd1);
    @(negedge CLOCK_50);
    check("tick_to_start_latency", {30'd0, start}, {30'd0, first_start});
  endtask

  task automatic wait_idle(input string tag);
    int c;
    c = 0;
    while (busy && c < 3000) begin
      @(negedge CLOCK_50);
      c++;
    end
    check(tag, {31'd0, busy}, 32'd0);
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge CLOCK_50);
    reset = 1'b1;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    check("reset_outputs",
          {start, base_x, base_y, x, y, colour, plot, busy, frame_overrun, timeout_err},
          '0);
    exp_q.delete();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    frame_tick = 1'b0;
    active = '0;
    sprite_colour = {3'b011, 3'b101};
    set_pos(0, 0, 0, 0);
    do_reset();

    // First frame: draw only.
    set_pos(5, 7, 0, 0);
    push_sprite(5, 7, 3'b101);
    tick_pass(2'b01, 2'b01);
    wait_idle("pass1_idle");
    check("pass1_starts", 32'(n_starts), 32'd1);

    // Move: erase old, draw new.
    set_pos(6, 7, 0, 0);
    push_sprite(5, 7, 3'b000);
    push_sprite(6, 7, 3'b101);
    tick_pass(2'b01, 2'b01);
    wait_idle("pass2_idle");
    check("pass2_starts", 32'(n_starts), 32'd2);

    // Both sprites: sprite 0 must finish before sprite 1 starts.
    set_pos(10, 7, 20, 30);
    push_sprite(6, 7, 3'b000);
    push_sprite(10, 7, 3'b101);
    push_sprite(20, 30, 3'b011);
    exp_at_start1 = 13;
    tick_pass(2'b11, 2'b01);
    wait_idle("pass3_idle");
    check("pass3_starts", 32'(n_starts), 32'd3);
    exp_at_start1 = -1;

    // Overrun: second tick during a pass is dropped.
    check("overrun_clear", {31'd0, frame_overrun}, 32'd0);
    set_pos(11, 7, 20, 30);
    push_sprite(10, 7, 3'b000);
    push_sprite(11, 7, 3'b101);
    tick_pass(2'b01, 2'b01);
    repeat (4) @(negedge CLOCK_50);
    frame_tick = 1'b1;
    @(negedge CLOCK_50);
    frame_tick = 1'b0;
    wait_idle("pass4_idle");
    check("overrun_set", {31'd0, frame_overrun}, 32'd1);
    repeat (10) @(negedge CLOCK_50);
    check("no_second_pass", {31'd0, busy}, 32'd0);

    // Reset mid-draw, then a fresh draw with no erase.
    set_pos(12, 8, 20, 30);
    push_sprite(11, 7, 3'b000);
    push_sprite(12, 8, 3'b101);
    tick_pass(2'b01, 2'b01);
    for (int c = 0; c < 200 && exp_q.size() > 8; c++) @(negedge CLOCK_50);
    check("mid_draw_reached", {31'd0, (exp_q.size() <= 8)}, 32'd1);
    do_reset();
    set_pos(9, 9, 20, 30);
    push_sprite(9, 9, 3'b101);
    tick_pass(2'b01, 2'b01);
    wait_idle("pass5_idle");
    check("pass5_starts", 32'(n_starts), 32'd1);

    // Drawer 1 hangs: phase aborts, pass completes.
    hang1 = 1'b1;
    ignore1 = 1'b1;
    exp_at_start1 = 0;
    check("timeout_clear", {31'd0, timeout_err}, 32'd0);
    set_pos(12, 9, 40, 50);
    push_sprite(9, 9, 3'b000);
    push_sprite(12, 9, 3'b101);
    tick_pass(2'b11, 2'b01);
    wait_idle("pass6_idle");
    check("timeout_set", {31'd0, timeout_err}, 32'd1);
    check("pass6_starts", 32'(n_starts), 32'd3);
    hang1 = 1'b0;
    ignore1 = 1'b0;
    exp_at_start1 = -1;

    // Inactive sprite handling.
    do_reset();
    set_pos(30, 20, 0, 0);
    push_sprite(30, 20, 3'b101);
    tick_pass(2'b01, 2'b01);
    wait_idle("pass7_idle");
`ifdef SCHED_INACTIVE_ERASE_EN
    push_sprite(30, 20, 3'b000);
    tick_pass(2'b00, 2'b01);
    wait_idle("pass8_idle");
    check("pass8_starts", 32'(n_starts), 32'd1);
`else
    tick_pass(2'b00, 2'b00);
    wait_idle("pass8_idle");
    check("pass8_starts", 32'(n_starts), 32'd0);
`endif

    repeat (3) @(negedge CLOCK_50);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
